// File: rtl/mem_rsp_pkg.sv
// mem_rsp_pkg: state encoding and widths shared by the
// memory responder and its storage array.
package mem_rsp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_WAIT = 2'd1;
  localparam state_t S_RESP = 2'd2;

  localparam int CNT_W = 4;
  localparam int OFS_W = 2;

endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: DEPTH x DATA_W word store, synchronous write,
// combinational read, contents never reset.
module mem_word_array
  import mem_rsp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_access_responder.sv
// mem_access_responder: one-at-a-time fetch/load/store responder.
// Define MEM_ADDR_CHECK_EN to flag misaligned/out-of-range requests.
module mem_access_responder
  import mem_rsp_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Write,
  input  logic [ADDR_W-1:0] Req_Addr,
  input  logic [DATA_W-1:0] Req_WData,
  output logic              Rsp_Valid,
  input  logic              Rsp_Ready,
  output logic [DATA_W-1:0] Rsp_RData,
  output logic              Rsp_Err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              wr_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  logic              accept;
  logic              req_err;
  logic [IDX_W-1:0]  req_idx;
  logic              commit;
  logic              c_wr;
  logic              c_err;
  logic [IDX_W-1:0]  c_idx;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] rd_word;
  logic              arr_we;
  logic              unused_addr;

  assign Req_Ready   = Reset_n && (state == S_IDLE);
  assign accept      = Req_Valid && Req_Ready;
  assign req_idx     = Req_Addr[OFS_W +: IDX_W];
  assign unused_addr = ^Req_Addr;

`ifdef MEM_ADDR_CHECK_EN
  logic [ADDR_W-1:0] word_addr;
  assign word_addr = Req_Addr >> OFS_W;
  assign req_err   = (Req_Addr[OFS_W-1:0] != '0) ||
                     (word_addr >= ADDR_W'(DEPTH));
`else
  assign req_err = 1'b0;
`endif

  // Zero wait states commit on the accept edge, straight from the bus.
  assign c_wr    = NO_WAIT ? Req_Write : wr_q;
  assign c_err   = NO_WAIT ? req_err   : err_q;
  assign c_idx   = NO_WAIT ? req_idx   : idx_q;
  assign c_wdata = NO_WAIT ? Req_WData : wdata_q;
  assign commit  = NO_WAIT ? accept :
                   ((state == S_WAIT) && (cnt == '0));
  assign arr_we  = commit && c_wr && !c_err;

  mem_word_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (CLK),
    .we    (arr_we),
    .waddr (c_idx),
    .wdata (c_wdata),
    .raddr (c_idx),
    .rdata (rd_word)
  );

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        wr_q    <= Req_Write;
        err_q   <= req_err;
        idx_q   <= req_idx;
        wdata_q <= Req_WData;
        cnt     <= CNT_INIT;
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= c_err;
        rsp_rdata <= c_err ? '0 :
                     (c_wr ? c_wdata : rd_word);
      end else if (state == S_RESP && Rsp_Ready) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
      end

      unique case (1'b1)
        (state == S_IDLE): begin
          if (accept) begin
            state <= NO_WAIT ? S_RESP : S_WAIT;
          end
        end
        (state == S_WAIT): begin
          if (cnt == '0) begin
            state <= S_RESP;
          end
        end
        (state == S_RESP): begin
          if (Rsp_Ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Rsp_Valid = rsp_valid;
  assign Rsp_RData = rsp_rdata;
  assign Rsp_Err   = rsp_err;

endmodule

// File: tb/tb_mem_access_responder.sv
// tb_mem_access_responder: two responders (2 and 0 wait states)
// checked every cycle against a transaction-level memory model.
module tb_mem_access_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  mem_access_responder #(.WAIT_CYCLES(2)) dut_w2 (
    .CLK(clk), .Reset_n(rst_n[0]),
    .Req_Valid(req_valid[0]), .Req_Ready(req_ready[0]),
    .Req_Write(req_write[0]), .Req_Addr(req_addr[0]),
    .Req_WData(req_wdata[0]), .Rsp_Valid(rsp_valid[0]),
    .Rsp_Ready(rsp_ready[0]), .Rsp_RData(rsp_rdata[0]),
    .Rsp_Err(rsp_err[0])
  );

  mem_access_responder #(.WAIT_CYCLES(0)) dut_w0 (
    .CLK(clk), .Reset_n(rst_n[1]),
    .Req_Valid(req_valid[1]), .Req_Ready(req_ready[1]),
    .Req_Write(req_write[1]), .Req_Addr(req_addr[1]),
    .Req_WData(req_wdata[1]), .Rsp_Valid(rsp_valid[1]),
    .Rsp_Ready(rsp_ready[1]), .Rsp_RData(rsp_rdata[1]),
    .Rsp_Err(rsp_err[1])
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int wc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef MEM_ADDR_CHECK_EN
    return (a % 4 != 0) || (a / 4 >= 256);
`else
    return (a === 32'hx);
`endif
  endfunction

  // Model: memory image plus one outstanding transaction per DUT.
  bit          m_busy [2];
  int          m_cnt  [2];
  bit          m_wr   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wd   [2];
  logic [31:0] m_data [2];
  bit          m_err  [2];
  logic [31:0] m_last [2] = '{32'h0, 32'h0};
  logic [31:0] m_mem  [2][256];

  task automatic m_commit(input int i);
    int idx;
    idx = int'((m_addr[i] / 4) % 256);
    m_err[i] = addr_bad(m_addr[i]);
    if (m_err[i]) m_data[i] = 32'h0;
    else if (m_wr[i]) begin
      m_mem[i][idx] = m_wd[i];
      m_data[i] = m_wd[i];
    end else m_data[i] = m_mem[i][idx];
    m_last[i] = m_data[i];
  endtask

  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst_n[i] !== 1'b1) begin
          m_busy[i] = 1'b0;
          m_last[i] = 32'h0;
        end
        ev = m_busy[i] && (m_cnt[i] >= wc(i));
        chk($sformatf("w%0d_req_ready", wc(i)), 32'(req_ready[i]),
            32'(rst_n[i] && !m_busy[i]));
        chk($sformatf("w%0d_rsp_valid", wc(i)), 32'(rsp_valid[i]),
            32'(ev));
        chk($sformatf("w%0d_rsp_err", wc(i)), 32'(rsp_err[i]),
            32'(ev && m_err[i]));
        chk($sformatf("w%0d_rsp_rdata", wc(i)), rsp_rdata[i],
            m_last[i]);
        if (rst_n[i] === 1'b1) begin
          if (!m_busy[i]) begin
            if (req_valid[i]) begin
              m_busy[i] = 1'b1;
              m_cnt[i]  = 0;
              m_wr[i]   = req_write[i];
              m_addr[i] = req_addr[i];
              m_wd[i]   = req_wdata[i];
              if (wc(i) == 0) m_commit(i);
            end
          end else if (m_cnt[i] < wc(i)) begin
            m_cnt[i]++;
            if (m_cnt[i] == wc(i)) m_commit(i);
          end else if (rsp_ready[i]) begin
            m_busy[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic start_req(input int i, input bit w,
                           input logic [31:0] a, input logic [31:0] d);
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_accept(input int i, output int waited,
                             output int at);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!req_ready[i] && waited < 50);
    if (!req_ready[i]) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: dut %0d never ready", i);
    end
    @(posedge clk);
    at = int'($time / 10);
    #1;
    req_valid[i] = 1'b0;
    req_write[i] = ~req_write[i];
    req_addr[i]  = req_addr[i] ^ 32'h0000_0044;
    req_wdata[i] = ~req_wdata[i];
  endtask

  task automatic wait_rsp(input int i, input int hold,
                          output logic [31:0] got, output bit err,
                          output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[i] && lat < 50);
    if (!rsp_valid[i]) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rsp_timeout: dut %0d no response", i);
    end
    got = rsp_rdata[i];
    err = rsp_err[i];
    if (hold > 0) begin
      repeat (hold - 1) @(negedge clk);
      @(posedge clk);
      #1;
      rsp_ready[i] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input int i, input bit w, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] got,
                      output bit err, output int lat);
    int wt, at;
    start_req(i, w, a, d);
    wait_accept(i, wt, at);
    wait_rsp(i, 0, got, err, lat);
  endtask

  initial begin
    logic [31:0] got;
    bit          err;
    int          lat, wt, at1, at2;

    for (int i = 0; i < 2; i++) begin
      rst_n[i]     = 1'b1;
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = 32'h0;
      req_wdata[i] = 32'h0;
      rsp_ready[i] = 1'b1;
    end
    #1;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready_low", 32'(req_ready[0]), 32'h0);
    chk("reset_rdata_zero", rsp_rdata[0], 32'h0);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready[0]), 32'h1);
    @(posedge clk);
    #1;

    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, got, err, lat);
    chk("store_latency", lat, 3);
    chk("store_echo", got, 32'hDEADBEEF);
    xact(0, 1'b0, 32'h10, 32'h0, got, err, lat);
    chk("load_latency", lat, 3);
    chk("load_raw", got, 32'hDEADBEEF);

    xact(0, 1'b1, 32'h0, 32'hA5A50001, got, err, lat);
    xact(0, 1'b1, 32'h3FC, 32'h5555AAAA, got, err, lat);
    xact(0, 1'b0, 32'h400, 32'h0, got, err, lat);
`ifdef MEM_ADDR_CHECK_EN
    chk("oob_load_data", got, 32'h0);
    chk("oob_load_err", 32'(err), 32'h1);
`else
    chk("wrap_load_data", got, 32'hA5A50001);
    chk("wrap_load_err", 32'(err), 32'h0);
`endif
    xact(0, 1'b0, 32'h3FC, 32'h0, got, err, lat);
    chk("top_word", got, 32'h5555AAAA);

    xact(0, 1'b1, 32'h13, 32'hCAFEF00D, got, err, lat);
`ifdef MEM_ADDR_CHECK_EN
    chk("misalign_err", 32'(err), 32'h1);
`else
    chk("misalign_err", 32'(err), 32'h0);
`endif
    xact(0, 1'b0, 32'h10, 32'h0, got, err, lat);
`ifdef MEM_ADDR_CHECK_EN
    chk("misalign_unchanged", got, 32'hDEADBEEF);
`else
    chk("misalign_ignored", got, 32'hCAFEF00D);
`endif

    rsp_ready[0] = 1'b0;
    start_req(0, 1'b1, 32'h40, 32'h0BADF00D);
    wait_accept(0, wt, at1);
    start_req(0, 1'b0, 32'h40, 32'h0);
    wait_rsp(0, 5, got, err, lat);
    chk("bp_data", got, 32'h0BADF00D);
    wait_accept(0, wt, at2);
    chk("bp_queued_wait", wt, 1);
    wait_rsp(0, 0, got, err, lat);
    chk("bp_load", got, 32'h0BADF00D);

    start_req(0, 1'b0, 32'h0, 32'h0);
    wait_accept(0, wt, at1);
    start_req(0, 1'b0, 32'h3FC, 32'h0);
    wait_rsp(0, 0, got, err, lat);
    wait_accept(0, wt, at2);
    chk("w2_spacing", at2 - at1, 4);
    wait_rsp(0, 0, got, err, lat);
    chk("w2_b2b_data", got, 32'h5555AAAA);

    xact(0, 1'b1, 32'h20, 32'h11112222, got, err, lat);
    start_req(0, 1'b1, 32'h20, 32'h12345678);
    wait_accept(0, wt, at1);
    rst_n[0] = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    @(posedge clk);
    #1;
    xact(0, 1'b0, 32'h20, 32'h0, got, err, lat);
    chk("reset_drop_store", got, 32'h11112222);
    xact(0, 1'b0, 32'h3FC, 32'h0, got, err, lat);
    chk("reset_keeps_commit", got, 32'h5555AAAA);

    xact(1, 1'b1, 32'h0, 32'h600DCAFE, got, err, lat);
    chk("w0_store_latency", lat, 1);
    xact(1, 1'b0, 32'h0, 32'h0, got, err, lat);
    chk("w0_load_latency", lat, 1);
    chk("w0_load_data", got, 32'h600DCAFE);
    start_req(1, 1'b0, 32'h0, 32'h0);
    wait_accept(1, wt, at1);
    start_req(1, 1'b1, 32'h8, 32'h00000077);
    wait_rsp(1, 0, got, err, lat);
    wait_accept(1, wt, at2);
    chk("w0_spacing", at2 - at1, 2);
    wait_rsp(1, 0, got, err, lat);
    xact(1, 1'b0, 32'h8, 32'h0, got, err, lat);
    chk("w0_b2b_data", got, 32'h00000077);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
